// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, optional two-entry skid buffer,
// synchronous flush, and saturating stall/drop statistics for the hazard-unit debug port.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             alive_q;
  logic             in_fire, out_fire, stall;
  logic [CNT_W:0]   drop_sum;

  assign out_valid = (state_q != EMPTY) && !flush;
  assign out_data  = main_q;

  // With the skid buffer, in_ready depends only on registers (plus flush),
  // which breaks the combinational ready path between stages.
  generate
    if (SKID != 0) begin : g_rdy_reg
      assign in_ready = alive_q && (state_q != FULL) && !flush;
    end else begin : g_rdy_comb
      assign in_ready = alive_q && ((state_q == EMPTY) || out_ready) && !flush;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign stall    = (state_q != EMPTY) && !out_ready && !flush;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      alive_q <= 1'b1;
    end
  end

  // One spare bit catches the overflow when adding up to two dropped entries.
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(occupancy);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush) begin
        drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
    end
  end

endmodule
